// File: rtl/feistel_engine_if.sv
// Bundles the block engine's handshake and F-function signals.
// Parameters must match the feistel_engine instance that uses it.
//   in_valid/in_ready/in_data/in_decrypt : block input, valid/ready handshake
//   r_feist_data/round_idx/feistel_res   : loop to the external F-function and key schedule
//   out_valid/out_ready/transp_data      : result output, valid/ready handshake
//   busy                                 : engine holds a block (RUN or DONE)
// Handshake rule: a transfer happens on a rising clk edge where both valid
// and ready are 1. The producer keeps its data steady while valid is 1 and
// ready is 0. Ready never depends combinationally on valid.
// modport master: the engine side. modport slave: the environment side.
interface feistel_engine_if #(
    parameter int CIPHER_WIDTH  = 64,
    parameter int FEISTEL_WIDTH = CIPHER_WIDTH / 2,
    parameter int ROUNDS        = 16,
    parameter int RW            = ($clog2(ROUNDS) > 1) ? $clog2(ROUNDS) : 1
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CIPHER_WIDTH-1:0]  in_data;
    logic                     in_decrypt;
    logic [FEISTEL_WIDTH-1:0] r_feist_data;
    logic [RW-1:0]            round_idx;
    logic [FEISTEL_WIDTH-1:0] feistel_res;
    logic                     out_valid;
    logic                     out_ready;
    logic [CIPHER_WIDTH-1:0]  transp_data;
    logic                     busy;

    modport master (
        input  in_valid, in_data, in_decrypt, feistel_res, out_ready,
        output in_ready, r_feist_data, round_idx, out_valid, transp_data, busy
    );

    modport slave (
        output in_valid, in_data, in_decrypt, feistel_res, out_ready,
        input  in_ready, r_feist_data, round_idx, out_valid, transp_data, busy
    );
endinterface

// File: rtl/feistel_engine.sv
// Iterative Feistel cipher engine. It runs one round per clock and uses an
// external combinational F-function.
//   clk       : rising-edge clock
//   rst       : asynchronous, active-high reset
//   bus       : feistel_engine_if.master (block in, F-function loop, block out)
//   state_dbg : current FSM state (0 IDLE, 1 RUN, 2 DONE)
// Timing: the block is accepted on one edge. ROUNDS RUN edges follow, and the
// last of them moves the engine to DONE. The result is held in DONE until
// out_ready is 1.
module feistel_engine #(
    parameter int CIPHER_WIDTH  = 64,
    parameter int FEISTEL_WIDTH = CIPHER_WIDTH / 2,
    parameter int ROUNDS        = 16,
    parameter int RW            = ($clog2(ROUNDS) > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    feistel_engine_if.master  bus,
    output logic [1:0]        state_dbg
);
    if (CIPHER_WIDTH < 8 || (CIPHER_WIDTH % 2) != 0) begin : g_bad_width
        $error("feistel_engine: CIPHER_WIDTH must be even and >= 8");
    end
    if (FEISTEL_WIDTH != CIPHER_WIDTH / 2) begin : g_bad_half
        $error("feistel_engine: FEISTEL_WIDTH must equal CIPHER_WIDTH/2");
    end
    if (ROUNDS < 1) begin : g_bad_rounds
        $error("feistel_engine: ROUNDS must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [RW-1:0] LAST_CNT = RW'(ROUNDS - 1);

    state_t                   state_q,     state_d;
    logic [FEISTEL_WIDTH-1:0] l_q,         l_d;
    logic [FEISTEL_WIDTH-1:0] r_q,         r_d;
    logic [RW-1:0]            cnt_q,       cnt_d;
    logic                     mode_q,      mode_d;
    logic [CIPHER_WIDTH-1:0]  transp_q,    transp_d;
    logic                     in_ready_q,  in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q,      busy_d;

    always_comb begin
        state_d     = state_q;
        l_d         = l_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        transp_d    = transp_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    l_d        = bus.in_data[CIPHER_WIDTH-1:FEISTEL_WIDTH];
                    r_d        = bus.in_data[FEISTEL_WIDTH-1:0];
                    mode_d     = bus.in_decrypt;
                    cnt_d      = '0;
                    state_d    = ST_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_RUN: begin
                l_d = r_q;
                r_d = l_q ^ bus.feistel_res;
                if (cnt_q == LAST_CNT) begin
                    // Final round with the output swap: R_n || L_n.
                    // cnt holds its value here, so it never wraps.
                    transp_d    = {l_q ^ bus.feistel_res, r_q};
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            l_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            transp_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_q         <= l_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            transp_q    <= transp_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // round_idx is decoded from registers only. Decrypt walks the subkeys backwards.
    assign bus.round_idx    = (state_q == ST_RUN) ? (mode_q ? (LAST_CNT - cnt_q) : cnt_q) : '0;
    assign bus.r_feist_data = r_q;
    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.busy         = busy_q;
    assign bus.transp_data  = transp_q;
    assign state_dbg        = state_q;
endmodule
